// File: rtl/ws2812_frame_ctrl_if.sv
// rtl/ws2812_frame_ctrl_if.sv - host write / driver fetch signal bundle for ws2812_frame_ctrl
interface ws2812_frame_ctrl_if;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [23:0] wr_color;
  logic        wr_ready;
  logic        commit;
  logic        commit_pending;
  logic        leddata_start;
  logic [5:0]  leddata_addr;
  logic [23:0] leddata_color;
  logic        leddata_valid;
  logic        frame_done;

  // Host/driver side: drives requests, observes results
  modport master (
    output wr_en, wr_addr, wr_color, commit, leddata_start, leddata_addr,
    input  wr_ready, commit_pending, leddata_color, leddata_valid, frame_done
  );

  // Frame controller side
  modport slave (
    input  wr_en, wr_addr, wr_color, commit, leddata_start, leddata_addr,
    output wr_ready, commit_pending, leddata_color, leddata_valid, frame_done
  );
endinterface

// File: rtl/ws2812_frame_ctrl.sv
// rtl/ws2812_frame_ctrl.sv - LED color frame store with 2-clock driver fetch; WS2812_FRAME_DBLBUF_EN enables double buffering
module ws2812_frame_ctrl #(
  parameter int N_LEDS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  ws2812_frame_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_OUT} state_t;

  localparam logic [6:0] DEPTH    = 7'(N_LEDS);
  localparam logic [6:0] LAST_IDX = 7'(N_LEDS - 1);

  state_t      r_state;
  logic        r_start_q;
  logic        r_ready_en;
  logic        r_done_arm;
  logic [5:0]  r_addr;
  logic [23:0] r_rd_data;

  logic        w_fetch;
  logic        w_wr_ok;
  logic        w_rd_in_range;

  // Rising edge of the driver start line
  assign w_fetch       = bus.leddata_start & ~r_start_q;
  // Driver read owns the array during S_RD; host is held off that cycle
  assign bus.wr_ready  = r_ready_en & (r_state != S_RD);
  // Out-of-range host writes are handshaked but dropped
  assign w_wr_ok       = bus.wr_en & bus.wr_ready & ({1'b0, bus.wr_addr} < DEPTH);
  assign w_rd_in_range = ({1'b0, r_addr} < DEPTH);

`ifdef WS2812_FRAME_DBLBUF_EN
  logic        r_bank;
  logic        r_pending;
  logic        w_swap;
  logic [23:0] r_mem [0:1][0:N_LEDS-1];

  // A fetch of LED 0 is the frame boundary where a pending commit takes effect
  assign w_swap = (r_state == S_IDLE) & w_fetch & (bus.leddata_addr == 6'd0) & r_pending;
  assign bus.commit_pending = r_pending;

  // Bank select and commit bookkeeping; a commit coinciding with a swap re-arms
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank    <= 1'b0;
      r_pending <= 1'b0;
    end else if (w_swap) begin
      r_bank    <= ~r_bank;
      r_pending <= bus.commit;
    end else if (bus.commit) begin
      r_pending <= 1'b1;
    end
  end

  // Host writes the back bank, driver reads the front bank; contents are not reset
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[~r_bank][bus.wr_addr] <= bus.wr_color;
    if (r_state == S_RD) r_rd_data <= w_rd_in_range ? r_mem[r_bank][r_addr] : 24'h000000;
  end
`else
  logic [23:0] r_mem [0:N_LEDS-1];
  logic        w_unused_commit;

  assign w_unused_commit    = bus.commit;
  assign bus.commit_pending = 1'b0;

  // Single shared bank; contents are not reset
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[bus.wr_addr] <= bus.wr_color;
    if (r_state == S_RD) r_rd_data <= w_rd_in_range ? r_mem[r_addr] : 24'h000000;
  end
`endif

  // Fetch FSM with registered driver outputs and end-of-frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= S_IDLE;
      r_start_q         <= 1'b0;
      r_ready_en        <= 1'b0;
      r_addr            <= 6'd0;
      r_done_arm        <= 1'b0;
      bus.leddata_color <= 24'h000000;
      bus.leddata_valid <= 1'b0;
      bus.frame_done    <= 1'b0;
    end else begin
      r_start_q      <= bus.leddata_start;
      r_ready_en     <= 1'b1;
      r_done_arm     <= 1'b0;
      bus.frame_done <= r_done_arm;
      case (r_state)
        S_IDLE: begin
          if (w_fetch) begin
            r_addr            <= bus.leddata_addr;
            bus.leddata_valid <= 1'b0;
            r_state           <= S_RD;
          end
        end
        S_RD: begin
          r_state <= S_OUT;
        end
        S_OUT: begin
          bus.leddata_color <= r_rd_data;
          bus.leddata_valid <= 1'b1;
          r_done_arm        <= ({1'b0, r_addr} == LAST_IDX);
          r_state           <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// tb/tb_ws2812_frame_ctrl.sv - directed self-checking bench for ws2812_frame_ctrl
module tb_ws2812_frame_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   errs   = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ws2812_frame_ctrl_if a_if ();
  ws2812_frame_ctrl_if b_if ();

  ws2812_frame_ctrl #(.N_LEDS(64)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  ws2812_frame_ctrl #(.N_LEDS(40)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_a(input logic [5:0] addr);
    a_if.leddata_start = 1'b1;
    a_if.leddata_addr  = addr;
    tick;
    a_if.leddata_start = 1'b0;
    tick;
    tick;
  endtask

  task automatic fetch_chk_a(input string tag, input logic [5:0] addr, input logic [23:0] exp);
    a_if.leddata_start = 1'b1;
    a_if.leddata_addr  = addr;
    tick;
    chk({tag, "_valid_t0"}, a_if.leddata_valid, 0);
    chk({tag, "_ready_rd"}, a_if.wr_ready, 0);
    a_if.leddata_start = 1'b0;
    tick;
    chk({tag, "_valid_t1"}, a_if.leddata_valid, 0);
    tick;
    chk({tag, "_valid_t2"}, a_if.leddata_valid, 1);
    chk({tag, "_color"}, a_if.leddata_color, exp);
  endtask

  // With double buffering the data is placed in both banks so later fetches see it
  task automatic host_write_a(input logic [5:0] addr, input logic [23:0] color);
    a_if.wr_en    = 1'b1;
    a_if.wr_addr  = addr;
    a_if.wr_color = color;
    tick;
    a_if.wr_en = 1'b0;
`ifdef WS2812_FRAME_DBLBUF_EN
    a_if.commit = 1'b1;
    tick;
    a_if.commit = 1'b0;
    fetch_a(6'd0);
    a_if.wr_en    = 1'b1;
    a_if.wr_addr  = addr;
    a_if.wr_color = color;
    tick;
    a_if.wr_en = 1'b0;
`endif
  endtask

  initial begin
    int   rises;
    int   lows;
    logic pv;

    rst_n = 1'b0;
    a_if.wr_en = 1'b0; a_if.wr_addr = '0; a_if.wr_color = '0; a_if.commit = 1'b0;
    a_if.leddata_start = 1'b0; a_if.leddata_addr = '0;
    b_if.wr_en = 1'b0; b_if.wr_addr = '0; b_if.wr_color = '0; b_if.commit = 1'b0;
    b_if.leddata_start = 1'b0; b_if.leddata_addr = '0;
    tick;
    tick;

    // Reset state
    chk("rst_wr_ready", a_if.wr_ready, 0);
    chk("rst_valid", a_if.leddata_valid, 0);
    chk("rst_color", a_if.leddata_color, 0);
    chk("rst_frame_done", a_if.frame_done, 0);
    chk("rst_pending", a_if.commit_pending, 0);
    rst_n = 1'b1;
    tick;
    chk("ready_after_release", a_if.wr_ready, 1);

    // Basic write then 2-clock fetch
    host_write_a(6'd5, 24'h0F0101);
    fetch_chk_a("f5", 6'd5, 24'h0F0101);

    // Host write held across a fetch: stalled only in S_RD
    a_if.leddata_start = 1'b1;
    a_if.leddata_addr  = 6'd5;
    tick;
    a_if.wr_en    = 1'b1;
    a_if.wr_addr  = 6'd10;
    a_if.wr_color = 24'hAABBCC;
    chk("hold_valid_cleared", a_if.leddata_valid, 0);
    chk("hold_color_kept", a_if.leddata_color, 24'h0F0101);
    chk("hold_ready_rd", a_if.wr_ready, 0);
    a_if.leddata_start = 1'b0;
    tick;
    chk("hold_ready_out", a_if.wr_ready, 1);
    tick;
    a_if.wr_en = 1'b0;
    chk("hold_valid", a_if.leddata_valid, 1);
    chk("hold_color", a_if.leddata_color, 24'h0F0101);
`ifdef WS2812_FRAME_DBLBUF_EN
    host_write_a(6'd10, 24'hAABBCC);
`endif
    fetch_chk_a("f10", 6'd10, 24'hAABBCC);
    tick;
    chk("f10_no_frame_done", a_if.frame_done, 0);

    // Last LED: frame_done one cycle after valid, single pulse
    host_write_a(6'd63, 24'h3F3F3F);
    fetch_chk_a("f63", 6'd63, 24'h3F3F3F);
    chk("f63_fd_t2", a_if.frame_done, 0);
    tick;
    chk("f63_fd_t3", a_if.frame_done, 1);
    tick;
    chk("f63_fd_t4", a_if.frame_done, 0);

    // Shorter chain: out-of-range write dropped, out-of-range fetch reads zero
    b_if.wr_en    = 1'b1;
    b_if.wr_addr  = 6'd39;
    b_if.wr_color = 24'h123456;
    tick;
    b_if.wr_addr  = 6'd50;
    b_if.wr_color = 24'hFFFFFF;
    tick;
    b_if.wr_en = 1'b0;
    b_if.leddata_start = 1'b1;
    b_if.leddata_addr  = 6'd39;
    tick;
    b_if.leddata_start = 1'b0;
    tick;
    tick;
    chk("b39_valid", b_if.leddata_valid, 1);
`ifndef WS2812_FRAME_DBLBUF_EN
    chk("b39_color", b_if.leddata_color, 24'h123456);
`endif
    chk("b39_fd_t2", b_if.frame_done, 0);
    tick;
    chk("b39_fd_t3", b_if.frame_done, 1);
    tick;
    chk("b39_fd_t4", b_if.frame_done, 0);
    b_if.leddata_start = 1'b1;
    b_if.leddata_addr  = 6'd50;
    tick;
    b_if.leddata_start = 1'b0;
    tick;
    tick;
    chk("b50_valid", b_if.leddata_valid, 1);
    chk("b50_color", b_if.leddata_color, 24'h000000);
    tick;
    chk("b50_no_frame_done", b_if.frame_done, 0);

    // Start held high for 10 cycles yields one fetch
    host_write_a(6'd7, 24'h070707);
    a_if.leddata_start = 1'b1;
    a_if.leddata_addr  = 6'd7;
    rises = 0;
    lows  = 0;
    pv    = a_if.leddata_valid;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (!a_if.wr_ready) lows++;
      if (a_if.leddata_valid && !pv) rises++;
      pv = a_if.leddata_valid;
    end
    a_if.leddata_start = 1'b0;
    tick;
    tick;
    chk("held_valid_rises", rises, 1);
    chk("held_rd_cycles", lows, 1);
    chk("held_color", a_if.leddata_color, 24'h070707);

    // Reset one cycle after a start edge abandons the fetch
    a_if.leddata_start = 1'b1;
    a_if.leddata_addr  = 6'd7;
    tick;
    a_if.leddata_start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", a_if.leddata_valid, 0);
    chk("midrst_ready", a_if.wr_ready, 0);
    tick;
    tick;
    chk("midrst_valid_later", a_if.leddata_valid, 0);
    chk("midrst_color", a_if.leddata_color, 0);
    rst_n = 1'b1;
    tick;
    chk("midrst_ready_release", a_if.wr_ready, 1);
    chk("midrst_valid_release", a_if.leddata_valid, 0);
    fetch_chk_a("after_rst", 6'd5, 24'h0F0101);

`ifdef WS2812_FRAME_DBLBUF_EN
    // Back-bank write invisible until commit and a fetch of LED 0
    host_write_a(6'd0, 24'h111111);
    a_if.wr_en    = 1'b1;
    a_if.wr_addr  = 6'd0;
    a_if.wr_color = 24'h010F01;
    tick;
    a_if.wr_en = 1'b0;
    fetch_chk_a("db_old", 6'd0, 24'h111111);
    chk("db_pending_idle", a_if.commit_pending, 0);
    a_if.commit = 1'b1;
    tick;
    a_if.commit = 1'b0;
    chk("db_pending_set", a_if.commit_pending, 1);
    a_if.commit = 1'b1;
    tick;
    a_if.commit = 1'b0;
    chk("db_pending_again", a_if.commit_pending, 1);
    fetch_chk_a("db_new", 6'd0, 24'h010F01);
    chk("db_pending_clear", a_if.commit_pending, 0);
    a_if.commit = 1'b1;
    tick;
    a_if.commit = 1'b0;
    a_if.leddata_start = 1'b1;
    a_if.leddata_addr  = 6'd0;
    a_if.commit        = 1'b1;
    tick;
    a_if.leddata_start = 1'b0;
    a_if.commit        = 1'b0;
    chk("db_swap_commit_pending", a_if.commit_pending, 1);
    tick;
    tick;
    chk("db_swap_back_color", a_if.leddata_color, 24'h111111);
`else
    // Single bank: commit ignored, writes visible immediately
    a_if.commit = 1'b1;
    tick;
    a_if.commit = 1'b0;
    chk("sb_pending_tied", a_if.commit_pending, 0);
    host_write_a(6'd0, 24'h010F01);
    fetch_chk_a("sb_shared", 6'd0, 24'h010F01);
    chk("sb_pending_after", a_if.commit_pending, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
